// File: rtl/main_memory_responder.sv
// Main-memory responder for the cache controller's memory bus.
// It commits single-word writes and returns 4-word aligned block refills after a fixed latency.
module main_memory_responder #(
  parameter  int ADDR_WIDTH  = 10,
  parameter  int DATA_WIDTH  = 32,
  parameter  int BLOCK_WORDS = 4,
  parameter  int LATENCY     = 4,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  ReadValid,
  output logic [IDX_W-1:0]      ReadIndex,
  output logic                  Ready,
  output logic                  Busy
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    WCOMMIT,
    BURST
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic [IDX_W-1:0]      beat_q, beat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  mem_we;
  logic [IDX_W-1:0]      beat_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // The first beat fetched leaving WAIT is beat 0; each later one is the successor of the current beat.
  assign beat_nxt = (state_q == WAIT) ? '0 : beat_q + IDX_W'(1);
  assign rd_addr  = {addr_q[ADDR_WIDTH-1:IDX_W], beat_nxt};

  always_comb begin
    // NOTE: every signal gets a default first, so no branch leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    beat_d     = beat_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (MemWrite || MemRead) begin
          state_d    = WAIT;
          cnt_d      = CNT_W'(LATENCY - 1);
          addr_d     = Address;
          wdata_d    = WriteData;
          is_write_d = MemWrite;  // a write wins when both requests are raised
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (is_write_q) begin
            mem_we  = 1'b1;
            state_d = WCOMMIT;
          end else begin
            state_d = BURST;
            beat_d  = '0;
            rdata_d = mem_q[rd_addr];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WCOMMIT: state_d = IDLE;
      BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
          beat_d  = '0;  // ReadData keeps the final beat after the burst ends
        end else begin
          beat_d  = beat_nxt;
          rdata_d = mem_q[rd_addr];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples the pre-edge values.
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      beat_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      beat_q     <= beat_d;
      rdata_q    <= rdata_d;
    end
  end

  // NOTE: the memory array is cleared on reset because reset must return every word to zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 2**ADDR_WIDTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign ReadData  = rdata_q;
  assign ReadValid = (state_q == BURST);
  assign ReadIndex = beat_q;
  assign Ready     = (state_q == WCOMMIT) || ((state_q == BURST) && (beat_q == LAST_BEAT));
  assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench for main_memory_responder.
// A cycle-count transaction model predicts the outputs, and directed literal checks pin that model.
module tb_main_memory_responder;
  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 4;
  localparam int IW  = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          MemRead, MemWrite;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          ReadValid;
  logic [IW-1:0] ReadIndex;
  logic          Ready, Busy;

  int checks = 0;
  int errors = 0;

  main_memory_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .BLOCK_WORDS(BW),
    .LATENCY    (LAT)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .ReadValid(ReadValid),
    .ReadIndex(ReadIndex),
    .Ready    (Ready),
    .Busy     (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model. m_k counts the cycles since the acceptance edge; the cycle after E0 is 1.
  logic [DW-1:0] m_mem [1024];
  bit            m_active, m_write;
  int            m_k;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_active = 0;
      m_write  = 0;
      m_k      = 0;
      m_rdata  = '0;
    end else begin
      if (!m_active) begin
        if (MemWrite || MemRead) begin
          m_active = 1;
          m_k      = 1;
          m_write  = MemWrite;
          m_addr   = Address;
          m_wdata  = WriteData;
        end
      end else begin
        m_k++;
        if (m_k > (m_write ? LAT + 1 : LAT + BW)) begin
          m_active = 0;
          m_k      = 0;
        end
      end
      if (m_active && m_write && m_k == LAT + 1) m_mem[m_addr] = m_wdata;
      if (m_active && !m_write && m_k > LAT)
        m_rdata = m_mem[(int'(m_addr) / BW) * BW + (m_k - LAT - 1)];
    end
  end

  // Compare process, run 2 time units after each rising edge.
  logic [DW-1:0] beats[$];
  int            ready_cnt = 0;

  always @(posedge CLK) begin
    bit exp_valid, exp_ready;
    int exp_idx;
    #2;
    exp_ready = m_active && (m_k == (m_write ? LAT + 1 : LAT + BW));
    exp_valid = m_active && !m_write && (m_k > LAT);
    exp_idx   = exp_valid ? (m_k - LAT - 1) : 0;
    check("busy",       32'(Busy),      32'(m_active));
    check("ready",      32'(Ready),     32'(exp_ready));
    check("read_valid", 32'(ReadValid), 32'(exp_valid));
    check("read_index", 32'(ReadIndex), 32'(exp_idx));
    check("read_data",  ReadData,       m_rdata);
    if (ReadValid) beats.push_back(ReadData);
    if (Ready) ready_cnt++;
  end

  // Raises a request, holds it until Ready is seen, then drops it. The scramble flag
  // randomises Address/WriteData every cycle while the request is in flight.
  task automatic request(input bit wr, input bit rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit scramble, output int lat);
    @(negedge CLK);
    MemWrite  = wr;
    MemRead   = rd;
    Address   = a;
    WriteData = d;
    beats.delete();
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge CLK);
      #3;
      if (c == 1) check("busy_after_e0", 32'(Busy), 32'd1);
      if (Ready) begin
        lat = c;
        break;
      end
      if (scramble) begin
        @(negedge CLK);
        Address   = AW'($urandom);
        WriteData = $urandom;
      end
    end
    if (lat == 0) check("ready_timeout", 32'd0, 32'd1);
    @(negedge CLK);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic check_beats(input string name, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                             input logic [DW-1:0] b2, input logic [DW-1:0] b3);
    check({name, "_count"}, 32'(beats.size()), 32'd4);
    if (beats.size() == 4) begin
      check({name, "_b0"}, beats[0], b0);
      check({name, "_b1"}, beats[1], b1);
      check({name, "_b2"}, beats[2], b2);
      check({name, "_b3"}, beats[3], b3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rc;
    bit found;

    RST = 1'b1;  MemRead = 1'b0;  MemWrite = 1'b1;  Address = '0;  WriteData = 32'h5A5A;
    #1 RST = 1'b0;

    // Reset holds everything idle even with a write request present.
    repeat (2) @(posedge CLK);
    #3;
    check("rst_ready", 32'(Ready), 32'd0);
    check("rst_busy",  32'(Busy),  32'd0);
    check("rst_rdata", ReadData,   32'd0);
    @(negedge CLK);
    MemWrite = 1'b0;
    RST      = 1'b1;

    request(0, 1, 10'd0, '0, 0, lat);
    check("rd0_latency", 32'(lat), 32'(LAT + BW));
    check_beats("rd0", 32'h0, 32'h0, 32'h0, 32'h0);

    // A write produces a single Ready in the cycle after E4 and no beats.
    request(1, 0, 10'd0, 32'h2805, 0, lat);
    check("wr_latency", 32'(lat), 32'(LAT + 1));
    check("wr_no_beats", 32'(beats.size()), 32'd0);
    request(0, 1, 10'd0, '0, 0, lat);
    check_beats("rd_after_wr", 32'h2805, 32'h0, 32'h0, 32'h0);

    // Block alignment: the request for word 4 is served from base 4 in beat order 0..3.
    request(1, 0, 10'd5, 32'h30205, 0, lat);
    request(0, 1, 10'd4, '0, 0, lat);
    check_beats("align", 32'h0, 32'h30205, 32'h0, 32'h0);
    request(0, 1, 10'd7, '0, 0, lat);
    check_beats("align_off3", 32'h0, 32'h30205, 32'h0, 32'h0);

    // Raising both requests gives write-only timing.
    rc = ready_cnt;
    request(1, 1, 10'd9, 32'hABCD, 0, lat);
    check("both_latency", 32'(lat), 32'(LAT + 1));
    check("both_no_beats", 32'(beats.size()), 32'd0);
    check("both_one_ready", 32'(ready_cnt - rc), 32'd1);
    request(0, 1, 10'd8, '0, 0, lat);
    check_beats("both_rd", 32'h0, 32'hABCD, 32'h0, 32'h0);

    // Inputs wiggle while Busy; only the values latched at acceptance take effect.
    request(1, 0, 10'h20, 32'h1111, 1, lat);
    request(0, 1, 10'h22, '0, 1, lat);
    check_beats("stable", 32'h1111, 32'h0, 32'h0, 32'h0);

    // Reset in the middle of a burst.
    request(1, 0, 10'h41, 32'h5555, 0, lat);
    rc = ready_cnt;
    @(negedge CLK);
    MemRead = 1'b1;
    Address = 10'h40;
    found   = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge CLK);
      #3;
      if (ReadValid && ReadIndex == 2'd1) begin
        found = 1;
        break;
      end
    end
    check("midburst_reached_beat1", 32'(found), 32'd1);
    check("midburst_beat1_data", ReadData, 32'h5555);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("midrst_ready", 32'(Ready),     32'd0);
    check("midrst_valid", 32'(ReadValid), 32'd0);
    check("midrst_index", 32'(ReadIndex), 32'd0);
    check("midrst_busy",  32'(Busy),      32'd0);
    check("midrst_rdata", ReadData,       32'd0);
    MemRead = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    check("midrst_no_ready", 32'(ready_cnt - rc), 32'd0);

    request(1, 0, 10'h100, 32'h7777, 0, lat);
    check("post_rst_wr_latency", 32'(lat), 32'(LAT + 1));
    request(0, 1, 10'h40, '0, 0, lat);
    check_beats("post_rst_cleared", 32'h0, 32'h0, 32'h0, 32'h0);
    request(0, 1, 10'h100, '0, 0, lat);
    check_beats("post_rst_new", 32'h7777, 32'h0, 32'h0, 32'h0);

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
